// File: rtl/boot_pkg.sv
// Shared types and width helpers for the boot loader sequencer.
package boot_pkg;

  // Top-level sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStretch,
    StRun,
    StErr
  } boot_state_t;

  // Bits needed to hold values 0..max_val; never narrower than one bit so that
  // a zero-length stretch still yields a legal counter.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned MinCntW = 1;

endpackage

// File: rtl/boot_loader_seq_if.sv
// Image stream handshake plus instruction-memory write port.
interface boot_loader_seq_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;

  // Environment side: drives the image stream, observes the memory writes.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_addr,
    input  mem_data,
    input  mem_we
  );

  // Loader side: consumes the image stream, drives the memory writes.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_addr,
    output mem_data,
    output mem_we
  );

endinterface

// File: rtl/boot_timer.sv
// Loadable saturating up/down counter with clear, enable and a terminal-value flag.
module boot_timer #(
  parameter int unsigned W         = 4,
  parameter bit          CountDown = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_val_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats count; both directions saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (CountDown) begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end else begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/boot_loader_seq.sv
// Boot sequencer: loads a fixed-size image into instruction memory, stretches
// core reset, then releases the core. A stalled source ends in a sticky error.
module boot_loader_seq
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IMG_WORDS   = 256,
  parameter int unsigned RST_STRETCH = 5,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  boot_loader_seq_if.slave  bus,
  output logic              core_rst,
  output logic              boot_done,
  output logic              boot_err
);

  // One extra bit so IMG_WORDS = 2^ADDR_W reaches its terminal compare unwrapped.
  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned TmrW = cnt_w(TIMEOUT);
  localparam int unsigned StrW = cnt_w(RST_STRETCH);

  localparam logic [CntW-1:0] LastWord = CntW'(IMG_WORDS - 1);
  localparam logic [TmrW-1:0] TmrLast  = TmrW'(TIMEOUT - 1);
  localparam logic [StrW-1:0] StrInit  = StrW'(RST_STRETCH);
  // Stretch ends on the edge that takes the downcounter from 1 to 0.
  localparam logic [StrW-1:0] StrLast  = StrW'(1);

  boot_state_t       state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              core_rst_q, core_rst_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_err_q, boot_err_d;

  logic xfer;
  logic last_word;
  logic tmr_clr, tmr_en, tmr_term;
  logic str_load, str_en, str_term;

  assign xfer      = (state_q == StLoad) && in_ready_q && bus.in_valid;
  assign last_word = (count_q == LastWord);

  // Idle-gap watchdog: counts cycles in LOAD since the last accepted word.
  boot_timer #(
    .W         (TmrW),
    .CountDown (1'b0)
  ) u_idle_tmr (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (tmr_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (tmr_en),
    .term_val_i (TmrLast),
    .term_o     (tmr_term)
  );

  // Post-load core reset stretch.
  boot_timer #(
    .W         (StrW),
    .CountDown (1'b1)
  ) u_stretch_tmr (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (1'b0),
    .load_i     (str_load),
    .load_val_i (StrInit),
    .en_i       (str_en),
    .term_val_i (StrLast),
    .term_o     (str_term)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    core_rst_d  = core_rst_q;
    boot_done_d = boot_done_q;
    boot_err_d  = boot_err_q;
    tmr_clr     = 1'b1;
    tmr_en      = 1'b0;
    str_load    = 1'b0;
    str_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d    = StLoad;
        in_ready_d = 1'b1;
        core_rst_d = 1'b1;
      end

      StLoad: begin
        tmr_clr = xfer;
        tmr_en  = !xfer;
        if (xfer) begin
          mem_we_d   = 1'b1;
          mem_addr_d = count_q[ADDR_W-1:0];
          mem_data_d = bus.in_data;
          count_d    = count_q + 1'b1;
          if (last_word) begin
            // Drop ready on the accepting edge so no extra word slips in.
            in_ready_d = 1'b0;
            if (RST_STRETCH == 0) begin
              state_d = StRun;
            end else begin
              state_d  = StStretch;
              str_load = 1'b1;
            end
          end
        end else if (tmr_term) begin
          state_d    = StErr;
          in_ready_d = 1'b0;
          boot_err_d = 1'b1;
        end
      end

      StStretch: begin
        in_ready_d = 1'b0;
        core_rst_d = 1'b1;
        str_en     = 1'b1;
        if (str_term) state_d = StRun;
      end

      // core_rst/boot_done follow one edge after entering RUN.
      StRun: begin
        in_ready_d  = 1'b0;
        core_rst_d  = 1'b0;
        boot_done_d = 1'b1;
      end

      StErr: begin
        in_ready_d  = 1'b0;
        core_rst_d  = 1'b1;
        boot_done_d = 1'b0;
        boot_err_d  = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; synchronous reset drops any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      core_rst_q  <= 1'b1;
      boot_done_q <= 1'b0;
      boot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      core_rst_q  <= core_rst_d;
      boot_done_q <= boot_done_d;
      boot_err_q  <= boot_err_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign core_rst     = core_rst_q;
  assign boot_done    = boot_done_q;
  assign boot_err     = boot_err_q;

endmodule
